// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell with a registered carry, operands consumed LSB-first.
// Optional SERIAL_ADD_OVF_EN adds a registered two's-complement overflow output (ovf).
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] s_sh;
    logic [WIDTH-1:0] s_nxt;
    logic             c_reg;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_carry;
    logic             last_bit;

    assign fa_sum   = a_sh[0] ^ b_sh[0] ^ c_reg;
    assign fa_carry = (a_sh[0] & b_sh[0]) | (a_sh[0] & c_reg) | (b_sh[0] & c_reg);
    assign last_bit = (cnt == LAST);

    // Only the upper WIDTH-1 sum bits are kept between edges; the bit that
    // would fall off the bottom is never needed, the full word is s_nxt.
    assign s_nxt = {fa_sum, s_sh};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            c_reg <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        c_reg <= cin;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    s_sh  <= s_nxt[WIDTH-1:1];
                    c_reg <= fa_carry;
                    cnt   <= cnt + 1'b1;
                    if (last_bit) begin
                        sum  <= s_nxt;
                        cout <= fa_carry;
`ifdef SERIAL_ADD_OVF_EN
                        // c_reg is the carry into the MSB on the final bit
                        ovf  <= c_reg ^ fa_carry;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
